// File: rtl/load_unit.sv
// rtl/load_unit.sv - MEM-stage load engine: aligned bus read, lane select, sign/zero extension, AdEL

// Widens an IN_W-bit field to 32 bits, replicating its MSB when sign_extend is set.
module extend #(
   parameter int IN_W = 8
) (
   input  logic [IN_W-1:0] din,
   input  logic            sign_extend,
   output logic [31:0]     dout
);

   assign dout = {{(32-IN_W){sign_extend & din[IN_W-1]}}, din};

endmodule

module load_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int RD_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [RD_WIDTH-1:0]   in_rd,
   output logic                  data_req,
   output logic [ADDR_WIDTH-1:0] data_addr,
   input  logic                  data_addr_ok,
   input  logic [31:0]           data_rdata,
   input  logic                  data_data_ok,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_data,
   output logic [RD_WIDTH-1:0]   out_rd,
   output logic                  out_adel,
   output logic [ADDR_WIDTH-1:0] out_badvaddr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [1:0]            lane_q, lane_d;
   logic [RD_WIDTH-1:0]   rd_q, rd_d;
   logic                  data_req_q, data_req_d;
   logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
   logic [31:0]           out_data_q, out_data_d;
   logic                  out_adel_q, out_adel_d;
   logic [ADDR_WIDTH-1:0] out_badvaddr_q, out_badvaddr_d;

   // Op decoding: bit 1 set means a full word (covers the 010/110/111 aliases),
   // bit 0 picks halfword over byte, bit 2 selects zero-fill.
   logic in_is_word, in_is_half, misaligned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] byte_ext, half_ext, load_result;

   assign in_is_word = in_op[1];
   assign in_is_half = ~in_op[1] & in_op[0];
   assign misaligned = (in_is_half & in_addr[0]) | (in_is_word & (in_addr[1:0] != 2'b00));

   // Pick the addressed byte and halfword lanes out of the returned word
   always_comb begin
      byte_sel = data_rdata[7:0];
      case (lane_q)
         2'd0: byte_sel = data_rdata[7:0];
         2'd1: byte_sel = data_rdata[15:8];
         2'd2: byte_sel = data_rdata[23:16];
         2'd3: byte_sel = data_rdata[31:24];
         default: byte_sel = data_rdata[7:0];
      endcase
      half_sel = lane_q[1] ? data_rdata[31:16] : data_rdata[15:0];
   end

   extend #(.IN_W(8)) u_ext_byte (
      .din         (byte_sel),
      .sign_extend (~op_q[2]),
      .dout        (byte_ext)
   );

   extend #(.IN_W(16)) u_ext_half (
      .din         (half_sel),
      .sign_extend (~op_q[2]),
      .dout        (half_ext)
   );

   assign load_result = op_q[1] ? data_rdata : (op_q[0] ? half_ext : byte_ext);

   // State and datapath registers; reset drops everything back to IDLE at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         op_q           <= 3'd0;
         lane_q         <= 2'd0;
         rd_q           <= '0;
         data_req_q     <= 1'b0;
         data_addr_q    <= '0;
         out_data_q     <= 32'd0;
         out_adel_q     <= 1'b0;
         out_badvaddr_q <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         lane_q         <= lane_d;
         rd_q           <= rd_d;
         data_req_q     <= data_req_d;
         data_addr_q    <= data_addr_d;
         out_data_q     <= out_data_d;
         out_adel_q     <= out_adel_d;
         out_badvaddr_q <= out_badvaddr_d;
      end
   end

   // Next-state: misaligned loads skip the bus and go straight to DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = misaligned ? DONE : REQ;
         REQ:  if (data_addr_ok) state_d = WAIT;
         WAIT: if (data_data_ok) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Register updates: latch the request on accept, capture the extended result on data_ok
   always_comb begin
      op_d           = op_q;
      lane_d         = lane_q;
      rd_d           = rd_q;
      data_req_d     = data_req_q;
      data_addr_d    = data_addr_q;
      out_data_d     = out_data_q;
      out_adel_d     = out_adel_q;
      out_badvaddr_d = out_badvaddr_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d   = in_op;
               lane_d = in_addr[1:0];
               rd_d   = in_rd;
               if (misaligned) begin
                  out_adel_d     = 1'b1;
                  out_badvaddr_d = in_addr;
                  out_data_d     = 32'd0;
               end else begin
                  out_adel_d     = 1'b0;
                  out_badvaddr_d = '0;
                  data_addr_d    = {in_addr[ADDR_WIDTH-1:2], 2'b00};
                  data_req_d     = 1'b1;
               end
            end
         end
         REQ:  if (data_addr_ok) data_req_d = 1'b0;
         WAIT: if (data_data_ok) out_data_d = load_result;
         default: ;
      endcase
   end

   // Outputs: handshake flags from the state, everything else straight from registers
   always_comb begin
      in_ready     = (state_q == IDLE) & ~reset;
      out_valid    = (state_q == DONE);
      data_req     = data_req_q;
      data_addr    = data_addr_q;
      out_data     = out_data_q;
      out_rd       = rd_q;
      out_adel     = out_adel_q;
      out_badvaddr = out_badvaddr_q;
   end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - self-checking bench for load_unit

module tb_load_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_addr;
   logic [4:0]  in_rd;
   logic        data_req;
   logic [31:0] data_addr;
   logic        data_addr_ok;
   logic [31:0] data_rdata;
   logic        data_data_ok;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_adel;
   logic [31:0] out_badvaddr;

   int tests = 0;
   int fails = 0;

   load_unit #(.ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_addr      (in_addr),
      .in_rd        (in_rd),
      .data_req     (data_req),
      .data_addr    (data_addr),
      .data_addr_ok (data_addr_ok),
      .data_rdata   (data_rdata),
      .data_data_ok (data_data_ok),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_rd       (out_rd),
      .out_adel     (out_adel),
      .out_badvaddr (out_badvaddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: size from op, alignment by modulo, lane by shift, sign by wraparound subtraction
   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] word, output logic adel);
      int unsigned size;
      logic [31:0] val, span;
      case (op)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      adel = (addr % size) != 0;
      if (adel) return 32'd0;
      if (size == 4) return word;
      span = (size == 1) ? 32'd256 : 32'd65536;
      val  = (word >> (8 * (addr % 4))) % span;
      if (op < 3'd4 && val >= span / 2) val = val - span;
      return val;
   endfunction

   // Issue one load, play the bus with the given stall lengths and check the result.
   // Called and returns one time unit after a rising edge, with the unit in IDLE.
   task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] word,
                           input int aok_w, input int dok_w, input int rdy_w,
                           input bit stray, input bit hold_next,
                           input logic [31:0] exp_data, input logic exp_adel);
      int cyc, nreq, wcnt, exp_lat;
      bit got, abad, sbad;
      logic [31:0] s_data, s_badv, s_addr;
      logic [4:0]  s_rd;
      logic        s_adel;
      chk({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_op = op; in_addr = addr; in_rd = rd; data_rdata = word;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1; nreq = 0; wcnt = 0; got = 0; abad = 0;
      while (!out_valid && cyc < 100) begin
         data_addr_ok = 1'b0; data_data_ok = 1'b0;
         if (data_req) begin
            nreq++;
            if (data_addr !== {addr[31:2], 2'b00}) abad = 1;
            if (!got && nreq > aok_w) begin
               data_addr_ok = 1'b1; got = 1;
            end else if (stray && nreq == 1) begin
               data_data_ok = 1'b1;
            end
         end else if (got) begin
            if (wcnt == dok_w) data_data_ok = 1'b1;
            wcnt++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      exp_lat = exp_adel ? 1 : 3 + aok_w + dok_w;
      chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " req cycles"}, nreq, exp_adel ? 0 : aok_w + 1);
      chk({tag, " addr stable"}, {31'd0, abad}, 32'd0);
      chk({tag, " data"}, out_data, exp_data);
      chk({tag, " adel"}, {31'd0, out_adel}, {31'd0, exp_adel});
      chk({tag, " badvaddr"}, out_badvaddr, exp_adel ? addr : 32'd0);
      chk({tag, " rd"}, {27'd0, out_rd}, {27'd0, rd});
      s_data = out_data; s_badv = out_badvaddr; s_addr = data_addr; s_rd = out_rd; s_adel = out_adel;
      sbad = 0;
      for (int i = 0; i < rdy_w; i++) begin
         if (hold_next) begin
            in_valid = 1'b1; in_op = 3'd3; in_addr = 32'h0000_2000; in_rd = 5'd7;
         end
         @(posedge clk); #1;
         if (!out_valid || in_ready || data_req || out_data !== s_data || out_badvaddr !== s_badv ||
             data_addr !== s_addr || out_rd !== s_rd || out_adel !== s_adel) sbad = 1;
      end
      if (rdy_w > 0) chk({tag, " done stall stable"}, {31'd0, sbad}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] word;
      logic [31:0] exp_data;
      logic        exp_adel;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_addr, r_word, r_exp;
      logic        r_adel;

      vecs[0]  = '{3'd3, 32'h0000_1000, 32'h8899_AABB, 32'h8899_AABB, 1'b0};
      vecs[1]  = '{3'd0, 32'h0000_1003, 32'h8011_2233, 32'hFFFF_FF80, 1'b0};
      vecs[2]  = '{3'd4, 32'h0000_1003, 32'h8011_2233, 32'h0000_0080, 1'b0};
      vecs[3]  = '{3'd1, 32'h0000_1002, 32'h8011_2233, 32'hFFFF_8011, 1'b0};
      vecs[4]  = '{3'd5, 32'h0000_1002, 32'h8011_2233, 32'h0000_8011, 1'b0};
      vecs[5]  = '{3'd0, 32'h0000_1000, 32'h8011_2233, 32'h0000_0033, 1'b0};
      vecs[6]  = '{3'd1, 32'h0000_1001, 32'h8011_2233, 32'h0000_0000, 1'b1};
      vecs[7]  = '{3'd3, 32'h0000_1002, 32'h8011_2233, 32'h0000_0000, 1'b1};
      vecs[8]  = '{3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[9]  = '{3'd7, 32'h0000_1006, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[10] = '{3'd5, 32'h0000_1000, 32'h8011_A233, 32'h0000_A233, 1'b0};
      vecs[11] = '{3'd0, 32'h0000_1001, 32'h8011_A233, 32'hFFFF_FFA2, 1'b0};

      reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_addr = 32'd0; in_rd = 5'd0;
      data_addr_ok = 1'b0; data_rdata = 32'd0; data_data_ok = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset data_req", {31'd0, data_req}, 32'd0);
      chk("reset data_addr", data_addr, 32'd0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_data", out_data, 32'd0);
      chk("reset out_rd", {27'd0, out_rd}, 32'd0);
      chk("reset out_adel", {31'd0, out_adel}, 32'd0);
      chk("reset badvaddr", out_badvaddr, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++)
         run_load($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, 5'(i + 3), vecs[i].word,
                  0, 0, 0, 1'b0, 1'b0, vecs[i].exp_data, vecs[i].exp_adel);

      // addr_ok late by 3 cycles with a stray data_ok, then a 5-cycle writeback stall with a queued request
      run_load("stall", 3'd3, 32'h0000_1000, 5'd9, 32'h1234_5678, 3, 0, 5, 1'b1, 1'b1,
               32'h1234_5678, 1'b0);
      run_load("queued", 3'd3, 32'h0000_2000, 5'd7, 32'h0BAD_F00D, 0, 2, 0, 1'b0, 1'b0,
               32'h0BAD_F00D, 1'b0);

      // Reset while the request is on the bus: data_req must fall without an edge
      in_valid = 1'b1; in_op = 3'd3; in_addr = 32'h0000_3000; in_rd = 5'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rstreq data_req before", {31'd0, data_req}, 32'd1);
      reset = 1'b1; #1;
      chk("rstreq data_req async", {31'd0, data_req}, 32'd0);
      chk("rstreq data_addr", data_addr, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset in WAIT, late data_ok afterwards must be ignored
      in_valid = 1'b1; in_op = 3'd3; in_addr = 32'h0000_3000; in_rd = 5'd4; data_rdata = 32'hCAFE_0001;
      @(posedge clk); #1;
      in_valid = 1'b0; data_addr_ok = 1'b1;
      @(posedge clk); #1;
      data_addr_ok = 1'b0;
      reset = 1'b1; #1;
      chk("rstwait data_req", {31'd0, data_req}, 32'd0);
      chk("rstwait out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstwait in_ready", {31'd0, in_ready}, 32'd0);
      #2 reset = 1'b0;
      data_data_ok = 1'b1;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      chk("late data_ok out_valid", {31'd0, out_valid}, 32'd0);
      chk("late data_ok out_data", out_data, 32'd0);
      chk("late data_ok in_ready", {31'd0, in_ready}, 32'd1);
      run_load("post reset", 3'd3, 32'h0000_3004, 5'd11, 32'h5555_AAAA, 0, 0, 0, 1'b0, 1'b0,
               32'h5555_AAAA, 1'b0);

      // Reset while an AdEL result waits for writeback
      in_valid = 1'b1; in_op = 3'd1; in_addr = 32'h0000_1001; in_rd = 5'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rstdone out_valid before", {31'd0, out_valid}, 32'd1);
      reset = 1'b1; #1;
      chk("rstdone out_valid async", {31'd0, out_valid}, 32'd0);
      chk("rstdone out_adel", {31'd0, out_adel}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         r_op   = 3'($urandom_range(0, 7));
         r_addr = $urandom;
         if ($urandom_range(0, 2) == 0) r_addr[1:0] = 2'b00;
         r_word = $urandom;
         r_exp  = ref_load(r_op, r_addr, r_word, r_adel);
         run_load($sformatf("rand%0d", i), r_op, r_addr, 5'($urandom), r_word,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  1'($urandom), 1'b0, r_exp, r_adel);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_unit.md
# load_unit

Memory-stage load engine for the mipsel32 core. It accepts one load from the MEM-stage pipeline register, issues a word-aligned read on the data SRAM-like bus, and waits for the response. It then selects the addressed byte or halfword, sign- or zero-extends it to 32 bits, and hands the result with its destination register to writeback. Misaligned addresses raise AdEL without touching the bus.

## Interface
- ADDR_WIDTH, 32, width of the load address and bus address.
- RD_WIDTH, 5, width of the destination-register tag carried through unchanged.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  load request present.
- in_ready  out  1  unit accepts a request this cycle.
- in_op  in  3  load type (opcode bits [2:0]):
  - 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU.
  - 010, 110 and 111 are treated as LW.
- in_addr  in  ADDR_WIDTH  effective byte address.
- in_rd  in  RD_WIDTH  destination register.
- data_req  out  1  bus read request.
- data_addr  out  ADDR_WIDTH  word-aligned bus address.
- data_addr_ok  in  1  bus accepted the address.
- data_rdata  in  32  bus read data, valid with data_data_ok.
- data_data_ok  in  1  read data returned.
- out_valid  out  1  result present.
- out_ready  in  1  writeback accepts the result.
- out_data  out  32  extended load result.
- out_rd  out  RD_WIDTH  destination register of the result.
- out_adel  out  1  address-error-on-load flag.
- out_badvaddr  out  ADDR_WIDTH  faulting address; 0 when out_adel=0.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = ~reset; all other outputs are quiescent.
  - On in_valid, latch op, addr and rd.
  - Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]≠00. If misaligned: out_adel=1, out_badvaddr=addr, out_data=0, next state DONE, no bus request.
  - Otherwise: data_addr={addr[ADDR_WIDTH-1:2],2'b00}, next state REQ.
- REQ:
  - data_req=1; data_addr is held stable.
  - On data_addr_ok sampled high at a clock edge, go to WAIT; data_req drops in the next cycle.
  - data_data_ok is ignored in REQ.
- WAIT:
  - data_req=0.
  - On data_data_ok, register the extracted result into out_data and go to DONE.
- DONE:
  - out_valid=1; out_data, out_rd, out_adel and out_badvaddr are held stable.
  - On out_ready, go to IDLE.
- Extraction uses lane = addr[1:0]:
  - Byte = data_rdata[8*lane+7:8*lane].
  - Half = addr[1] ? data_rdata[31:16] : data_rdata[15:0].
  - LB and LH replicate the MSB of the selected field into the upper bits. LBU and LHU zero-fill. LW passes the full word.
  - Extension uses the `extend` block (8→32 and 16→32, sign_extend selected per op).
- in_valid is ignored outside IDLE; in_ready=0 in REQ, WAIT and DONE.

## Timing
- Reset values:
  - state IDLE; data_req=0, data_addr=0, out_valid=0, out_data=0, out_rd=0, out_adel=0, out_badvaddr=0.
  - in_ready=0 while reset is high.
- Reset asserted in any state forces IDLE immediately, asynchronously. data_req and out_valid fall without waiting for an edge.
- A data_data_ok belonging to a pre-reset transaction arrives in IDLE and is ignored.
- Aligned load, best case:
  - Accept at edge 0; REQ in cycle 1.
  - addr_ok in cycle 1 gives WAIT in cycle 2.
  - data_ok in cycle 2 gives out_valid in cycle 3.
  - Minimum 3 cycles from accept to out_valid. One load in flight at a time.
- Misaligned load: out_valid in the cycle after accept (latency 1).
- Every stall (addr_ok low, data_ok low, out_ready low) adds exactly its duration to latency. No output changes while stalled.
- data_req is a registered output: it never glitches and is stable within a cycle.

## Test plan
- LW at addr 0x00001000; addr_ok in the first REQ cycle, data_rdata=0x8899AABB with data_ok in the first WAIT cycle -> data_addr=0x00001000, out_valid 3 cycles after accept, out_data=0x8899AABB, out_adel=0, out_rd unchanged.
- data_rdata=0x80112233 -> each case gives a single bus transaction to 0x00001000:
  - LB at 0x00001003 -> out_data 0xFFFFFF80.
  - LBU at 0x00001003 -> out_data 0x00000080.
  - LH at 0x00001002 -> out_data 0xFFFF8011.
  - LHU at 0x00001002 -> out_data 0x00008011.
  - LB at 0x00001000 -> out_data 0x00000033.
- LH at 0x00001001 and LW at 0x00001002 -> data_req never asserts; out_valid the cycle after accept with out_adel=1, out_badvaddr equal to the address, out_data=0.
- data_addr_ok held low for 3 cycles with a stray data_data_ok pulse during REQ -> data_req=1 and data_addr constant for all 4 REQ cycles; the stray pulse does not advance the FSM; the correct result follows the real data_ok.
- out_ready held low for 5 cycles in DONE, with in_valid=1 and a new address -> out_valid and all outputs are constant, in_ready=0, and the new request is accepted only after the handshake.
- Reset pulsed in WAIT, then data_data_ok arrives after reset release -> data_req=0 and out_valid=0 immediately, the late data_ok is ignored, and the next LW completes normally.
